// File: rtl/i2c_seq.sv
// I2C register-transaction sequencer: drives the four-register I2C master device
// to perform a single one-byte register write or register read per command.
module i2c_seq #(
    parameter logic [15:0] SCLH    = 16'd250,
    parameter logic [15:0] SCLL    = 16'd250,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_done,
    output logic        rsp_err,
    output logic [7:0]  rsp_code,
    output logic [7:0]  rsp_rdata,
    output logic        m_stb,
    output logic        m_we,
    output logic [1:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [1:0] ADDR_SET  = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_SCL  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    localparam logic [7:0] BIT_I2EN = 8'h40;
    localparam logic [7:0] BIT_STA  = 8'h20;
    localparam logic [7:0] BIT_STO  = 8'h10;
    localparam logic [7:0] BIT_SI   = 8'h08;
    localparam logic [7:0] BIT_AA   = 8'h04;

    localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

    typedef enum logic [3:0] {
        ST_INIT0,
        ST_INIT1,
        ST_INIT2,
        ST_IDLE,
        ST_STA,
        ST_WAIT,
        ST_STAT,
        ST_CHECK,
        ST_ACT1,
        ST_ACT2,
        ST_STO,
        ST_STO_CLR,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_done_q, rsp_done_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_code_q, rsp_code_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;
    logic [1:0]  m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        rd_q, rd_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;
    logic [7:0]  code_q, code_d;
    logic [19:0] tmo_q, tmo_d;

    logic        acc_we;
    logic [1:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [7:0]  exp_code;
    logic        bus_state;
    logic        acked;
    logic        timed_out;
    logic        unused_rdata;

    assign unused_rdata = ^m_rdata[31:8];
    assign acked        = m_stb_q & m_ack;
    assign timed_out    = (tmo_q >= TMO_LAST);

    assign bus_state = (state_q != ST_IDLE) && (state_q != ST_CHECK) && (state_q != ST_DONE);

    // The access each bus state performs; the step counter picks the post-status action.
    always_comb begin
        acc_we    = 1'b1;
        acc_addr  = ADDR_SET;
        acc_wdata = 32'h0;
        unique case (state_q)
            ST_INIT0:   begin acc_addr = ADDR_SCL; acc_wdata = {SCLH, SCLL}; end
            ST_INIT1:   begin acc_addr = ADDR_CLR; acc_wdata = {24'h0, BIT_I2EN | BIT_STA | BIT_SI | BIT_AA}; end
            ST_INIT2:   begin acc_addr = ADDR_SET; acc_wdata = {24'h0, BIT_I2EN}; end
            ST_STA:     begin acc_addr = ADDR_SET; acc_wdata = {24'h0, BIT_STA}; end
            ST_WAIT:    begin acc_we = 1'b0; acc_addr = ADDR_SET; end
            ST_STAT:    begin acc_we = 1'b0; acc_addr = ADDR_CLR; end
            ST_ACT1: begin
                unique case (step_q)
                    3'd0:    begin acc_addr = ADDR_DATA; acc_wdata = {24'h0, dev_q, 1'b0}; end
                    3'd1:    begin acc_addr = ADDR_DATA; acc_wdata = {24'h0, reg_q}; end
                    3'd2: begin
                        if (rd_q) begin
                            acc_addr  = ADDR_SET;
                            acc_wdata = {24'h0, BIT_STA};
                        end else begin
                            acc_addr  = ADDR_DATA;
                            acc_wdata = {24'h0, wdata_q};
                        end
                    end
                    3'd4:    begin acc_addr = ADDR_DATA; acc_wdata = {24'h0, dev_q, 1'b1}; end
                    3'd5:    begin acc_addr = ADDR_CLR; acc_wdata = {24'h0, BIT_SI | BIT_AA}; end
                    3'd6:    begin acc_we = 1'b0; acc_addr = ADDR_DATA; end
                    default: begin acc_addr = ADDR_SET; acc_wdata = 32'h0; end
                endcase
            end
            ST_ACT2: begin
                acc_addr  = ADDR_CLR;
                acc_wdata = ((step_q == 3'd0) || (step_q == 3'd4)) ? {24'h0, BIT_STA | BIT_SI}
                                                                   : {24'h0, BIT_SI};
            end
            ST_STO:     begin acc_addr = ADDR_SET; acc_wdata = {24'h0, BIT_STO}; end
            ST_STO_CLR: begin acc_addr = ADDR_CLR; acc_wdata = {24'h0, BIT_SI}; end
            default:    begin acc_we = 1'b1; end
        endcase
    end

    always_comb begin
        unique case (step_q)
            3'd0:    exp_code = 8'h08;
            3'd1:    exp_code = 8'h18;
            3'd2:    exp_code = 8'h28;
            3'd3:    exp_code = 8'h28;
            3'd4:    exp_code = 8'h10;
            3'd5:    exp_code = 8'h40;
            3'd6:    exp_code = 8'h58;
            default: exp_code = 8'hFF;
        endcase
    end

    // Every bus state strobes from a low-strobe cycle, so each access is followed by a gap.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_done_d  = rsp_done_q;
        rsp_err_d   = rsp_err_q;
        rsp_code_d  = rsp_code_q;
        rsp_rdata_d = rsp_rdata_q;
        m_stb_d     = m_stb_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        rd_d        = rd_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        step_d      = step_q;
        status_d    = status_q;
        err_d       = err_q;
        code_d      = code_q;
        tmo_d       = tmo_q;

        if (bus_state && !m_stb_q && !((state_q == ST_WAIT) && timed_out)) begin
            m_stb_d   = 1'b1;
            m_we_d    = acc_we;
            m_addr_d  = acc_addr;
            m_wdata_d = acc_wdata;
        end
        if (acked) begin
            m_stb_d = 1'b0;
        end

        unique case (state_q)
            ST_INIT0: if (acked) state_d = ST_INIT1;
            ST_INIT1: if (acked) state_d = ST_INIT2;
            ST_INIT2: begin
                if (acked) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    rd_d        = cmd_rd;
                    dev_d       = cmd_dev;
                    reg_d       = cmd_reg;
                    wdata_d     = cmd_wdata;
                    step_d      = 3'd0;
                    err_d       = 1'b0;
                    code_d      = 8'h00;
                    m_stb_d     = 1'b1;
                    m_we_d      = 1'b1;
                    m_addr_d    = ADDR_SET;
                    m_wdata_d   = {24'h0, BIT_STA};
                    state_d     = ST_STA;
                end
            end
            ST_STA: begin
                if (acked) begin
                    state_d = ST_WAIT;
                    tmo_d   = 20'd0;
                end
            end
            ST_WAIT: begin
                if (tmo_q != 20'hFFFFF) begin
                    tmo_d = tmo_q + 20'd1;
                end
                // A poll that returns SI beats a timeout expiring in the same cycle.
                if (acked && m_rdata[3]) begin
                    state_d = ST_STAT;
                end else if (timed_out && (acked || !m_stb_q)) begin
                    err_d   = 1'b1;
                    code_d  = 8'hFF;
                    state_d = ST_STO;
                end
            end
            ST_STAT: begin
                if (acked) begin
                    status_d = m_rdata[7:0];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (status_q != exp_code) begin
                    err_d   = 1'b1;
                    code_d  = status_q;
                    state_d = ST_STO;
                end else if (step_q == 3'd3) begin
                    state_d = ST_STO;
                end else begin
                    state_d = ST_ACT1;
                end
            end
            ST_ACT1: begin
                if (acked) begin
                    if (step_q == 3'd5) begin
                        step_d  = 3'd6;
                        tmo_d   = 20'd0;
                        state_d = ST_WAIT;
                    end else if (step_q == 3'd6) begin
                        rsp_rdata_d = m_rdata[7:0];
                        state_d     = ST_STO;
                    end else begin
                        state_d = ST_ACT2;
                    end
                end
            end
            ST_ACT2: begin
                if (acked) begin
                    step_d  = ((step_q == 3'd2) && rd_q) ? 3'd4 : step_q + 3'd1;
                    tmo_d   = 20'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_STO: if (acked) state_d = ST_STO_CLR;
            ST_STO_CLR: begin
                if (acked) begin
                    rsp_done_d = 1'b1;
                    rsp_err_d  = err_q;
                    rsp_code_d = code_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_done_d  = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_INIT0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT0;
            cmd_ready_q <= 1'b0;
            rsp_done_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= 8'h00;
            rsp_rdata_q <= 8'h00;
            m_stb_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= 2'd0;
            m_wdata_q   <= 32'h0;
            rd_q        <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            step_q      <= 3'd0;
            status_q    <= 8'h00;
            err_q       <= 1'b0;
            code_q      <= 8'h00;
            tmo_q       <= 20'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_code_q  <= rsp_code_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_stb_q     <= m_stb_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            rd_q        <= rd_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            step_q      <= step_d;
            status_q    <= status_d;
            err_q       <= err_d;
            code_q      <= code_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_code  = rsp_code_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_stb     = m_stb_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_seq.sv
// Directed bench for i2c_seq: a scripted single-cycle-ack device model plus
// a write log, checked against hand-written expected bus traffic.
module tb_i2c_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rd = 1'b0;
    logic [6:0]  cmd_dev = 7'h00;
    logic [7:0]  cmd_reg = 8'h00;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_done;
    logic        rsp_err;
    logic [7:0]  rsp_code;
    logic [7:0]  rsp_rdata;
    logic        m_stb;
    logic        m_we;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int checks = 0;
    int failures = 0;

    i2c_seq #(.SCLH(16'd250), .SCLL(16'd250), .TIMEOUT(20'd16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_code(rsp_code), .rsp_rdata(rsp_rdata),
        .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    // Device model: acks in the strobe cycle, raises SI on the second poll after a write.
    logic [7:0] statList [0:63];
    int         statIdx = 0;
    int         pollsSinceWr = 0;
    logic       siOn = 1'b0;
    logic [7:0] rdByte = 8'h00;

    assign m_ack = m_stb;

    always_comb begin
        m_rdata = 32'h0;
        case (m_addr)
            2'd0: m_rdata = {24'h0, 8'h40 | ((siOn && pollsSinceWr >= 1) ? 8'h08 : 8'h00)};
            2'd1: m_rdata = {24'h0, rdByte};
            2'd3: m_rdata = {24'h0, statList[statIdx[5:0]]};
            default: m_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (m_stb && m_ack) begin
            if (m_we) pollsSinceWr <= 0;
            else if (m_addr == 2'd0) pollsSinceWr <= pollsSinceWr + 1;
            if (!m_we && m_addr == 2'd3) statIdx <= statIdx + 1;
        end
    end

    // Bus and response log, sampled mid-cycle.
    logic [1:0]  wrAddr [0:255];
    logic [31:0] wrData [0:255];
    int          wrCnt = 0;
    int          pollCnt = 0;
    int          doneCnt = 0;
    logic        capErr = 1'b0;
    logic [7:0]  capCode = 8'h00;
    logic [7:0]  capRdata = 8'h00;

    always @(negedge clk) begin
        if (m_stb && m_ack) begin
            if (m_we) begin
                wrAddr[wrCnt[7:0]] <= m_addr;
                wrData[wrCnt[7:0]] <= m_wdata;
                wrCnt <= wrCnt + 1;
            end else if (m_addr == 2'd0) begin
                pollCnt <= pollCnt + 1;
            end
        end
        if (rsp_done) begin
            doneCnt  <= doneCnt + 1;
            capErr   <= rsp_err;
            capCode  <= rsp_code;
            capRdata <= rsp_rdata;
        end
    end

    logic [33:0] expWr [0:15];
    int          expN = 0;
    int          badAccept = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic addExp(input logic [1:0] a, input logic [31:0] d);
        expWr[expN] = {a, d};
        expN++;
    endtask

    task automatic verifyWrites(input string tag, input int start);
        checkOutput({tag, "_count"}, 64'(wrCnt - start), 64'(expN));
        for (int i = 0; i < expN; i++) begin
            checkOutput($sformatf("%s_wr%0d", tag, i),
                        {30'd0, wrAddr[(start + i) % 256], wrData[(start + i) % 256]},
                        {30'd0, expWr[i]});
        end
    endtask

    task automatic loadStatus(input int n, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input logic [7:0] c4, input logic [7:0] c5);
        logic [7:0] codes [0:5];
        codes[0] = c0; codes[1] = c1; codes[2] = c2;
        codes[3] = c3; codes[4] = c4; codes[5] = c5;
        for (int i = 0; i < n; i++) statList[(statIdx + i) % 64] = codes[i];
    endtask

    task automatic applyStimulus(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                                 input logic [7:0] wd, input logic keepValid);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        if (!keepValid) cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        int d0 = doneCnt;
        int n = 0;
        while (doneCnt == d0 && n < maxCycles) begin
            tick();
            if (cmd_valid && cmd_ready && doneCnt == d0) badAccept++;
            n++;
        end
        cmd_valid = 1'b0;
        checkOutput("done_seen", 64'(doneCnt != d0), 64'd1);
    endtask

    task automatic releaseAndCheckInit(input string tag);
        int start = wrCnt;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checkOutput({tag, "_ready_c5"}, 64'(cmd_ready), 64'd0);
        tick();
        checkOutput({tag, "_ready_c6"}, 64'(cmd_ready), 64'd1);
        expN = 0;
        addExp(2'd2, 32'h00FA00FA);
        addExp(2'd3, 32'h0000006C);
        addExp(2'd0, 32'h00000040);
        verifyWrites(tag, start);
    endtask

    initial begin
        int start;
        int p0;
        int n;

        // Reset values
        #2 rst = 1'b0;
        tick(); tick();
        checkOutput("reset_rsp", {44'd0, cmd_ready, rsp_done, rsp_err, rsp_code, rsp_rdata, m_stb},
                    64'd0);
        checkOutput("reset_bus", {29'd0, m_we, m_addr, m_wdata}, 64'd0);
        releaseAndCheckInit("init");

        // Register write, all codes as expected
        siOn = 1'b1;
        loadStatus(4, 8'h08, 8'h18, 8'h28, 8'h28, 8'h00, 8'h00);
        start = wrCnt;
        applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);
        waitDone(400);
        checkOutput("wr_err", 64'(capErr), 64'd0);
        checkOutput("wr_code", 64'(capCode), 64'h00);
        tick();
        checkOutput("wr_done_pulse", 64'(rsp_done), 64'd0);
        checkOutput("wr_ready_back", 64'(cmd_ready), 64'd1);
        expN = 0;
        addExp(2'd0, 32'h20);
        addExp(2'd1, 32'hA0); addExp(2'd3, 32'h28);
        addExp(2'd1, 32'h10); addExp(2'd3, 32'h08);
        addExp(2'd1, 32'hA5); addExp(2'd3, 32'h08);
        addExp(2'd0, 32'h10); addExp(2'd3, 32'h08);
        verifyWrites("wr", start);

        // Register read with repeated start
        loadStatus(6, 8'h08, 8'h18, 8'h28, 8'h10, 8'h40, 8'h58);
        rdByte = 8'h3C;
        start = wrCnt;
        applyStimulus(1'b1, 7'h68, 8'h00, 8'h00, 1'b0);
        waitDone(600);
        checkOutput("rd_err", 64'(capErr), 64'd0);
        checkOutput("rd_rdata", 64'(capRdata), 64'h3C);
        expN = 0;
        addExp(2'd0, 32'h20);
        addExp(2'd1, 32'hD0); addExp(2'd3, 32'h28);
        addExp(2'd1, 32'h00); addExp(2'd3, 32'h08);
        addExp(2'd0, 32'h20); addExp(2'd3, 32'h08);
        addExp(2'd1, 32'hD1); addExp(2'd3, 32'h28);
        addExp(2'd3, 32'h0C);
        addExp(2'd0, 32'h10); addExp(2'd3, 32'h08);
        verifyWrites("rd", start);

        // Address NACK aborts with the offending code
        loadStatus(2, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
        start = wrCnt;
        applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);
        waitDone(400);
        checkOutput("nack_err", 64'(capErr), 64'd1);
        checkOutput("nack_code", 64'(capCode), 64'h20);
        tick();
        checkOutput("nack_ready_back", 64'(cmd_ready), 64'd1);
        checkOutput("nack_rdata_hold", 64'(rsp_rdata), 64'h3C);
        expN = 0;
        addExp(2'd0, 32'h20);
        addExp(2'd1, 32'hA0); addExp(2'd3, 32'h28);
        addExp(2'd0, 32'h10); addExp(2'd3, 32'h08);
        verifyWrites("nack", start);

        // SI never set: timeout abort, cmd_valid held throughout must not be re-accepted
        siOn = 1'b0;
        start = wrCnt;
        p0 = pollCnt;
        badAccept = 0;
        applyStimulus(1'b0, 7'h22, 8'h33, 8'h44, 1'b1);
        waitDone(200);
        checkOutput("tmo_err", 64'(capErr), 64'd1);
        checkOutput("tmo_code", 64'(capCode), 64'hFF);
        checkOutput("tmo_polls", 64'(pollCnt - p0), 64'd8);
        checkOutput("tmo_no_accept", 64'(badAccept), 64'd0);
        expN = 0;
        addExp(2'd0, 32'h20);
        addExp(2'd0, 32'h10); addExp(2'd3, 32'h08);
        verifyWrites("tmo", start);
        n = wrCnt;
        for (int c = 0; c < 4; c++) tick();
        checkOutput("tmo_idle_after", 64'(wrCnt - n), 64'd0);

        // Reset during WAIT of a read: immediate zero outputs, no STOP, INIT replayed
        start = wrCnt;
        p0 = pollCnt;
        applyStimulus(1'b1, 7'h68, 8'h00, 8'h00, 1'b0);
        n = 0;
        while ((pollCnt - p0) < 2 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("rst_in_wait", 64'((pollCnt - p0) >= 2), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_rsp", {44'd0, cmd_ready, rsp_done, rsp_err, rsp_code, rsp_rdata, m_stb},
                    64'd0);
        checkOutput("rst_mid_bus", {29'd0, m_we, m_addr, m_wdata}, 64'd0);
        tick(); tick();
        checkOutput("rst_no_stop", 64'(wrCnt - start), 64'd1);
        releaseAndCheckInit("reinit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
